// File: rtl/soc_rst_pkg.sv
// rtl/soc_rst_pkg.sv - shared types and constants for the SoC reset controller
// Contents:
//   rst_state_t  sequencer states ASSERT -> REL_PERIPH -> RUN
//   CAUSE_*      bit positions inside the sticky reset-cause register
package soc_rst_pkg;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    REL_PERIPH = 2'd1,
    RUN        = 2'd2
  } rst_state_t;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_SW  = 2;
  localparam int CAUSE_W   = 3;

endpackage

// File: rtl/rst_sync2.sv
// rtl/rst_sync2.sv - two-flop synchronizer with a configurable reset value
// Ports:
//   clk    destination clock
//   rst_n  async active-low reset, loads RST_VAL into both flops
//   d      asynchronous input
//   q      synchronized output (2 cycles of latency)
module rst_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/soc_rst_ctrl.sv
// rtl/soc_rst_ctrl.sv - SoC reset sequencer: gathers reset sources, releases periph then core
// Optional build macro: SOC_RST_CTRL_SYNC_EN (2-flop synchronizers on i_por, i_wdt_rst_req, i_sw_rst_req)
// Ports:
//   i_clk          system clock
//   i_rst_n        async active-low board reset
//   i_por          power-on reset from wrap_por, active-high
//   i_wdt_rst_req  watchdog reset request, active-high
//   i_sw_rst_req   software reset request, active-high
//   i_cause_clr    pulse clearing o_rst_cause
//   o_rst_periph   reset for bus and peripherals, active-high
//   o_rst_core     reset for CPU core, active-high
//   o_rst_cause    sticky cause {sw, wdt, por/ext}
//   o_rst_done     one-cycle pulse on entry to RUN
module soc_rst_ctrl
  import soc_rst_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int CORE_DELAY  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_por,
  input  logic               i_wdt_rst_req,
  input  logic               i_sw_rst_req,
  input  logic               i_cause_clr,
  output logic               o_rst_periph,
  output logic               o_rst_core,
  output logic [CAUSE_W-1:0] o_rst_cause,
  output logic               o_rst_done
);

  localparam int MAX_CNT = (HOLD_CYCLES > CORE_DELAY) ? HOLD_CYCLES : CORE_DELAY;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);
  localparam logic [CAUSE_W-1:0] CAUSE_RST = CAUSE_W'(1 << CAUSE_POR);

  logic por_s;
  logic wdt_s;
  logic sw_s;

`ifdef SOC_RST_CTRL_SYNC_EN
  // POR sync resets to 1 so the board-reset release never looks like a POR-free window.
  rst_sync2 #(.RST_VAL(1'b1)) u_sync_por (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_por), .q(por_s)
  );
  rst_sync2 #(.RST_VAL(1'b0)) u_sync_wdt (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_wdt_rst_req), .q(wdt_s)
  );
  rst_sync2 #(.RST_VAL(1'b0)) u_sync_sw (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_sw_rst_req), .q(sw_s)
  );
`else
  assign por_s = i_por;
  assign wdt_s = i_wdt_rst_req;
  assign sw_s  = i_sw_rst_req;
`endif

  logic req;
  assign req = por_s | wdt_s | sw_s;

  rst_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CAUSE_W-1:0] cause_set;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ASSERT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (req) begin
      // Any request restarts the whole hold, whatever the current state.
      state_nxt = ASSERT;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ASSERT: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = REL_PERIPH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        REL_PERIPH: begin
          if (cnt == CORE_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = ASSERT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rst_periph <= 1'b1;
      o_rst_core   <= 1'b1;
      o_rst_done   <= 1'b0;
    end else begin
      o_rst_periph <= (state_nxt == ASSERT);
      o_rst_core   <= (state_nxt != RUN);
      o_rst_done   <= (state_nxt == RUN) && (state != RUN);
    end
  end

  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_POR] = por_s;
    cause_set[CAUSE_WDT] = wdt_s;
    cause_set[CAUSE_SW]  = sw_s;
  end

  // A cause arriving in the same cycle as a clear survives the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rst_cause <= CAUSE_RST;
    end else begin
      o_rst_cause <= (i_cause_clr ? '0 : o_rst_cause) | cause_set;
    end
  end

endmodule
